// File: rtl/bch15_pkg.sv
// Shared GF(16) constants, sequencer state encoding and inverse table for the
// BCH(15,7,t=2) decoder.
package bch15_pkg;

  localparam logic [4:0] GF_POLY    = 5'h13;
  localparam logic [8:0] BCH_GEN    = 9'h1D1;
  localparam logic [3:0] ALPHA      = 4'h2;
  localparam logic [3:0] ALPHA3     = 4'h8;
  localparam logic [3:0] ALPHA_INV  = 4'h9;
  localparam logic [3:0] ALPHA_INV2 = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYND,
    ST_LOC,
    ST_CHIEN,
    ST_DONE
  } state_t;

  // inv(0) has no meaning; it returns 0 and is only reached when S1 is zero.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h1: r = 4'h1;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'hD;
      4'h5: r = 4'hB;
      4'h6: r = 4'h7;
      4'h7: r = 4'h6;
      4'h8: r = 4'hF;
      4'h9: r = 4'h2;
      4'hA: r = 4'hC;
      4'hB: r = 4'h5;
      4'hC: r = 4'hA;
      4'hD: r = 4'h4;
      4'hE: r = 4'h3;
      4'hF: r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bch15_decode_sequencer_if.sv
// Word-in / result-out handshake bundle of the BCH(15,7) decode sequencer.
interface bch15_decode_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_codeword;
  logic [6:0]  out_msg;
  logic [1:0]  out_err_count;
  logic        out_uncorrectable;
  logic        busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_codeword, out_msg, out_err_count,
           out_uncorrectable, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_codeword, out_msg, out_err_count,
           out_uncorrectable, busy
  );
endinterface

// File: rtl/gf16_mult.sv
// Combinational GF(16) multiplier, field polynomial x^4+x+1.
module gf16_mult
  import bch15_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  logic [6:0] full;

  always_comb begin
    full = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) full = full ^ (7'(a) << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (full[i]) full = full ^ (7'(GF_POLY) << (i - 4));
    end
    p = full[3:0];
  end

endmodule

// File: rtl/bch15_decode_sequencer.sv
// Serial BCH(15,7,t=2) decoder: Horner syndromes, closed-form locator,
// serial Chien search, all on two time-shared GF(16) multipliers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a word, in_ready high
// ST_SYND  | 15 cycles of Horner syndrome update, bit 14 first
// ST_LOC   | one cycle: derive sigma1/sigma2, degree, uncorrectable flag
// ST_CHIEN | 15 cycles evaluating sigma at alpha^-j, j = 0..14
// ST_DONE  | result presented, held until out_ready
module bch15_decode_sequencer
  import bch15_pkg::*;
#(
  parameter bit FIXED_LATENCY = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  bch15_decode_sequencer_if.slave  bus
);

  state_t      state;
  logic [14:0] raw;
  logic [3:0]  acc1, acc2;
  logic [3:0]  cnt;
  logic [14:0] mask;
  logic [1:0]  root_cnt, deg;
  logic        uncorr;

  logic        in_ready_q, busy_q, out_valid_q, unc_q;
  logic [14:0] cw_q;
  logic [1:0]  err_q;

  logic [3:0]  ma_b, mb_b, prod_a, prod_b;

  // acc1/acc2 hold S1/S3 during SYND and t1/t2 during CHIEN.
  always_comb begin
    ma_b = ALPHA;
    mb_b = ALPHA3;
    case (state)
      ST_LOC: begin
        ma_b = acc1;
        mb_b = gf16_inv(acc1);
      end
      ST_CHIEN: begin
        ma_b = ALPHA_INV;
        mb_b = ALPHA_INV2;
      end
      default: ;
    endcase
  end

  gf16_mult u_mult_a (.a(acc1), .b(ma_b), .p(prod_a));
  gf16_mult u_mult_b (.a(acc2), .b(mb_b), .p(prod_b));

  // (S3 ^ S1^3) * inv(S1) rewritten as S1^2 ^ S3*inv(S1) so LOC needs two products.
  logic       s1_zero, loc_unc, loc_skip;
  logic [3:0] sigma2;
  logic [1:0] loc_deg;

  always_comb begin
    s1_zero  = (acc1 == 4'h0);
    loc_unc  = s1_zero && (acc2 != 4'h0);
    sigma2   = s1_zero ? 4'h0 : (prod_a ^ prod_b);
    loc_deg  = s1_zero ? 2'd0 : ((sigma2 == 4'h0) ? 2'd1 : 2'd2);
    loc_skip = (FIXED_LATENCY == 1'b0) && s1_zero;
  end

  logic        hit;
  logic [14:0] mask_nxt;
  logic [1:0]  rc_nxt;
  logic [14:0] fin_mask;
  logic [1:0]  fin_rc, fin_deg;
  logic        fin_unc, fin_fail, load_done;

  always_comb begin
    hit      = ((4'h1 ^ acc1 ^ acc2) == 4'h0);
    mask_nxt = mask | (15'(hit) << cnt);
    rc_nxt   = (hit && root_cnt != 2'd3) ? root_cnt + 2'd1 : root_cnt;
    fin_mask = mask_nxt;
    fin_rc   = rc_nxt;
    fin_deg  = deg;
    fin_unc  = uncorr;
    if (state == ST_LOC) begin
      fin_mask = '0;
      fin_rc   = 2'd0;
      fin_deg  = loc_deg;
      fin_unc  = loc_unc;
    end
    fin_fail  = fin_unc || (fin_rc != fin_deg);
    load_done = ((state == ST_LOC) && loc_skip) ||
                ((state == ST_CHIEN) && (cnt == 4'd14));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      raw         <= '0;
      acc1        <= '0;
      acc2        <= '0;
      cnt         <= '0;
      mask        <= '0;
      root_cnt    <= '0;
      deg         <= '0;
      uncorr      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cw_q        <= '0;
      err_q       <= '0;
      unc_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            raw        <= bus.in_data;
            acc1       <= '0;
            acc2       <= '0;
            cnt        <= 4'd14;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_SYND;
          end
        end
        ST_SYND: begin
          acc1 <= prod_a ^ {3'b000, raw[cnt]};
          acc2 <= prod_b ^ {3'b000, raw[cnt]};
          if (cnt == 4'd0) state <= ST_LOC;
          else cnt <= cnt - 4'd1;
        end
        ST_LOC: begin
          acc2     <= sigma2;
          deg      <= loc_deg;
          uncorr   <= loc_unc;
          cnt      <= 4'd0;
          mask     <= '0;
          root_cnt <= 2'd0;
          state    <= loc_skip ? ST_DONE : ST_CHIEN;
        end
        ST_CHIEN: begin
          acc1     <= prod_a;
          acc2     <= prod_b;
          mask     <= mask_nxt;
          root_cnt <= rc_nxt;
          if (cnt == 4'd14) state <= ST_DONE;
          else cnt <= cnt + 4'd1;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load_done) begin
        out_valid_q <= 1'b1;
        cw_q        <= fin_fail ? raw : (raw ^ fin_mask);
        err_q       <= fin_fail ? 2'd0 : fin_deg;
        unc_q       <= fin_fail;
      end
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.busy              = busy_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_codeword      = cw_q;
  assign bus.out_msg           = cw_q[14:8];
  assign bus.out_err_count     = err_q;
  assign bus.out_uncorrectable = unc_q;

endmodule

// File: doc/bch15_decode_sequencer.md
Name: bch15_decode_sequencer

Overview:
Multi-cycle, area-lean decoder for the BCH(15,7,t=2) code. It accepts one received 15-bit word over a valid/ready handshake and runs three phases on a single shared GF(16) datapath: serial Horner syndrome computation, error-locator solve, and serial Chien search. It then presents the corrected codeword and message with status. It replaces the fully unrolled combinational decode path where clocked operation and low area matter.

Parameters:
FIXED_LATENCY, 1, 1 = always run all 15 CHIEN cycles; 0 = skip CHIEN when no error is present (S1==0 and S3==0) or when the word is flagged uncorrectable in LOC.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word (high only in IDLE)
in_data  input  15  received word; bit i = coefficient of x^i; [14:8] message, [7:0] parity
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out_codeword  output  15  corrected word (raw word if uncorrectable)
out_msg  output  7  out_codeword[14:8]
out_err_count  output  2  number of bits corrected: 0, 1 or 2
out_uncorrectable  output  1  decoding failure detected
busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_codeword=0, out_err_count=0, out_uncorrectable=0, busy=0, in_ready=1. Reset asserted mid-operation aborts immediately; the captured word is discarded.
- GF(16) arithmetic:
  - Primitive polynomial x^4+x+1, so alpha=4'h2 and alpha^4=4'h3.
  - alpha^3=4'h8, alpha^-1=4'h9, alpha^-2=4'hD.
  - Addition is XOR; multiplication is polynomial product mod 0x13.
- States: IDLE -> SYND -> LOC -> CHIEN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_data, clear S1/S3, set cnt=14, go SYND.
- SYND (15 cycles, cnt 14 down to 0), once per cycle:
  - S1 <= S1*alpha ^ r[cnt]
  - S3 <= S3*alpha^3 ^ r[cnt]
  - After cnt=0, go LOC.
- LOC (1 cycle):
  - S1==0, S3==0: no error. sigma1=sigma2=0, deg=0.
  - S1==0, S3!=0: uncorrectable, deg=0.
  - S1!=0: sigma1=S1, sigma2=(S3 ^ S1^3)*inv(S1); deg=1 if sigma2==0, else 2.
  - Then load t1=sigma1, t2=sigma2, j=0, root count=0, mask=0, and go CHIEN. Exception: FIXED_LATENCY=0 with the no-error or uncorrectable case goes directly to DONE.
- CHIEN (15 cycles, j=0..14), once per cycle:
  - If 1^t1^t2==0: set mask[j] and increment root count (saturating at 3).
  - t1 <= t1*alpha^-1; t2 <= t2*alpha^-2.
  - After j=14, go DONE.
- Entry to DONE registers the outputs:
  - If uncorrectable, or root count != deg: out_codeword=raw word, out_err_count=0, out_uncorrectable=1.
  - Otherwise: out_codeword=raw ^ mask, out_err_count=deg, out_uncorrectable=0.
- DONE:
  - out_valid=1; outputs stay stable while out_ready=0.
  - On out_valid & out_ready: out_valid drops on the same edge and state goes IDLE.
  - No same-cycle turnaround: in_ready rises the cycle after the handshake.
- Latency from the accepting edge to out_valid high:
  - FIXED_LATENCY=1: exactly 31 edges.
  - FIXED_LATENCY=0 skip path: exactly 16 edges.
- in_valid outside IDLE is ignored; in_data need not be held after acceptance.
- Output data fields keep their last values after the handshake until the next DONE entry. Only out_valid qualifies them.

Decomposition:
- Package bch15_pkg:
  - Constants GF_POLY=5'h13, BCH_GEN=9'h1D1, ALPHA=4'h2, ALPHA3=4'h8, ALPHA_INV=4'h9, ALPHA_INV2=4'hD.
  - State enum.
  - Function gf16_inv as a 16-entry table.
- Sub-module gf16_mult: combinational 4x4 GF(16) multiplier. The sequencer uses 2 instances, time-shared across SYND/CHIEN and reused in LOC.

Test Plan:
- in_data=15'h0000, FIXED_LATENCY=1 -> out_valid exactly 31 edges after accept; out_codeword=0, out_msg=0, out_err_count=0, out_uncorrectable=0.
- in_data=15'h40E0 (codeword 15'h40E8 with bit 3 flipped) -> out_codeword=15'h40E8, out_msg=7'h40, out_err_count=1, out_uncorrectable=0.
- in_data=15'h00E9 (15'h40E8 with bits 14 and 0 flipped) -> out_codeword=15'h40E8, out_msg=7'h40, out_err_count=2.
- in_data=15'h0013 (S1=0, S3=4'h6) -> out_uncorrectable=1, out_codeword=15'h0013, out_err_count=0. With FIXED_LATENCY=0, out_valid 16 edges after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> outputs stable, in_ready=0; after the out_ready pulse, in_ready=1 the next cycle. Back-to-back words decode independently.
- Assert rst_n=0 during CHIEN (e.g. 20 edges after accept) -> all outputs reach reset values immediately without a clock; after release, a new 15'h40E8 decodes with out_err_count=0 in 31 edges.
